// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 32-bit multiply/divide unit producing HI/LO
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   start, op           launch request (taken only when idle) and operation
//                       00=MULT 01=MULTU 10=DIV 11=DIVU
//   inp1, inp2          multiplicand/dividend, multiplier/divisor
//   busy                operation in progress
//   done, div_by_zero   one-cycle completion pulse and divide-by-zero flag
//   hi, lo              product upper/lower, or remainder/quotient
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inp1,
  input  logic [WIDTH-1:0] inp2,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic                 is_div;
  logic                 neg_res;
  logic                 neg_rem;
  logic                 dz;
  logic [WIDTH-1:0]     operand;   // multiplicand magnitude, or divisor magnitude
  logic [WIDTH-1:0]     orig_a;    // unmodified inp1, returned as hi on divide by zero
  logic [2*WIDTH-1:0]   acc;       // {partial product | remainder, multiplier | quotient}

  logic                 neg1, neg2;
  logic [WIDTH-1:0]     abs1, abs2;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   acc_next;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;

  // Magnitudes of the incoming operands; signed ops are those with op[0]=0.
  always_comb begin
    neg1 = ~op[0] & inp1[WIDTH-1];
    neg2 = ~op[0] & inp2[WIDTH-1];
    abs1 = neg1 ? (~inp1 + 1'b1) : inp1;
    abs2 = neg2 ? (~inp2 + 1'b1) : inp2;
  end

  // One iteration of shift-add (multiply, LSB first) or restoring shift-subtract (divide).
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, operand};
    if (!is_div)
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    else if (div_diff[WIDTH])
      acc_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      acc_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Sign correction applied in the FIX cycle.
  always_comb begin
    prod_fix = neg_res ? (~acc + 1'b1) : acc;
    quo_fix  = neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      is_div      <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      dz          <= 1'b0;
      operand     <= '0;
      orig_a      <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      case (state)
        IDLE: begin
          done        <= 1'b0;
          div_by_zero <= 1'b0;
          if (start) begin
            is_div  <= op[1];
            neg_res <= neg1 ^ neg2;
            neg_rem <= neg1;
            dz      <= op[1] & (inp2 == '0);
            orig_a  <= inp1;
            operand <= op[1] ? abs2 : abs1;
            acc     <= {{WIDTH{1'b0}}, (op[1] ? abs1 : abs2)};
            count   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (dz) begin
            hi <= orig_a;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
          div_by_zero <= dz;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative 32-bit multiply/divide unit in the EX stage, beside the ALU bitwise/arith blocks.
- Takes the same two register operands the ALU logic blocks consume.
- Produces the HI/LO pair consumed by MFHI/MFLO on the EX/MEM result path.
- Radix-2, one bit per cycle. The pipeline stalls on `busy`.

Parameters:
- WIDTH, 32, operand width. Hi/lo are each WIDTH; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch operation; sampled only when busy=0
- op  input  2  00=MULT (signed), 01=MULTU, 10=DIV (signed), 11=DIVU
- inp1  input  WIDTH  multiplicand / dividend (rs)
- inp2  input  WIDTH  multiplier / divisor (rt)
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; hi/lo hold the new result in this cycle
- div_by_zero  output  1  pulses with done when a DIV/DIVU had inp2=0
- hi  output  WIDTH  MULT: upper product; DIV: remainder
- lo  output  WIDTH  MULT: lower product; DIV: quotient

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, div_by_zero = 0; hi = lo = 0; internal counters and accumulators cleared. Reset mid-operation aborts it: no done pulse, and the result is never written.
- States:
  - IDLE -> CALC on start=1 (edge E0). At E0 latch op, |inp1|, |inp2| (abs only for signed ops), the result sign and the remainder sign; count=0.
  - CALC: one iteration per edge, E1..E32. Exit to FIX when count reaches WIDTH-1 on the edge.
  - FIX (E33): apply sign correction; write hi/lo; done=1 for exactly this cycle; state -> IDLE.
- Latency: done is visible after E33, i.e. 33 cycles after the start edge, for every op.
- busy=1 from after E0 until E33; busy=0 in the cycle done=1.
- start while busy=1 is ignored, including in the FIX cycle.
- Back-to-back: start asserted in the done cycle is accepted, because busy=0 then.
- Multiply: shift-add on unsigned magnitudes into a 2*WIDTH accumulator. Signed result is the two's-complement negation of the 64-bit product when the operand signs differ.
- Divide: restoring shift-subtract on magnitudes.
  - Signed quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Invariant: inp1 = lo*inp2 + hi.
- 0x80000000 / -1 (DIV): lo=0x80000000, hi=0, no flag.
- Divide by zero (DIV or DIVU, inp2=0): full latency still runs; hi=inp1 (original value); lo=all ones; div_by_zero=1 with done.
- hi/lo change only on FIX or reset; they hold between operations.
- Operands are latched at E0; inp1/inp2/op changes during busy have no effect.
- All outputs registered; no combinational path from inputs to outputs.

Test Plan:
- MULTU inp1=0xFFFFFFFF, inp2=0xFFFFFFFF, start 1 cycle -> busy for 33 cycles, done pulse at E33, hi=0xFFFFFFFE, lo=0x00000001.
- MULT inp1=-3, inp2=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then MULT 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0x00000000.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 0xFFFFFFF9/2 -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU 100/0 -> done at E33, div_by_zero=1 for one cycle, hi=0x00000064, lo=0xFFFFFFFF. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start MULTU 5*6; pulse start again at E10 with different operands -> ignored, result lo=30, hi=0. Start a new op in the done cycle -> accepted; its done appears 33 cycles later.
- After a completed op (hi/lo nonzero), start another; assert reset at E12 -> busy=0, hi=lo=0 immediately (asynchronously), no done pulse. A following start after reset release runs normally.
